pipe_addsub: RTL and testbench

Parametrised, elastic add/subtract pipeline with valid/ready handshaking on both sides. It is the next generation of the team's registered adder. New behaviour over that adder:
- configurable pipeline depth
- per-transaction add/subtract select
- optional signed saturation
- overflow flagging with a sticky status bit
- a result counter

It sits between an operand producer and a result consumer, either of which may stall.

---
 rtl/pipe_addsub.sv | 69 ++++++
 tb/tb_pipe_addsub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: elastic add/subtract pipeline with optional saturation, sticky overflow and result counter
module pipe_addsub #(
  parameter int W = 16,
  parameter int STAGES = 2,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         ovf_clr,
  output logic [15:0]  res_cnt
);
  logic [STAGES-1:0] v, o, ld;
  logic [W-1:0] d [STAGES];
  logic [W:0] s;
  logic s_ovf, full, xfer;
  logic [W-1:0] r;
  always_comb begin
    s = op ? {a[W-1], a} - {b[W-1], b} : {a[W-1], a} + {b[W-1], b};
    s_ovf = s[W] ^ s[W-1];
    r = (SAT && s_ovf) ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
  end
  // a stage can load unless it and every stage after it is full while the consumer stalls
  always_comb begin
    full = 1'b1;
    ld = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full = full & v[i];
      ld[i] = out_ready | ~full;
    end
  end
  assign xfer = out_valid & out_ready;
  assign in_ready = ld[0];
  assign out_valid = v[STAGES-1];
  assign y = d[STAGES-1];
  assign ovf = o[STAGES-1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      o <= '0;
      d <= '{default: '0};
      ovf_sticky <= 1'b0;
      res_cnt <= '0;
    end else begin
      if (ld[0]) begin
        v[0] <= in_valid;
        d[0] <= r;
        o[0] <= s_ovf;
      end
      for (int i = 1; i < STAGES; i++)
        if (ld[i]) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
          o[i] <= o[i-1];
        end
      ovf_sticky <= (xfer & ovf) | (ovf_sticky & ~ovf_clr);
      res_cnt <= res_cnt + 16'(xfer);
    end
  end
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed vectors plus backpressure, sticky, reset and wrap sequences
module tb_pipe_addsub;
  logic clk = 1'b0;
  logic rst_n, in_valid, op, out_ready, ovf_clr;
  logic [15:0] a, b;
  logic in_valid2, op2, out_ready2;
  logic [15:0] a2, b2;
  logic in_ready0, out_valid0, ovf0, st0, in_ready1, out_valid1, ovf1, st1;
  logic in_ready2, out_valid2, ovf2, st2;
  logic [15:0] y0, y1, y2, cnt0, cnt1, cnt2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.W(16), .STAGES(2), .SAT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .op(op), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .ovf(ovf0), .ovf_sticky(st0),
    .ovf_clr(ovf_clr), .res_cnt(cnt0));
  pipe_addsub #(.W(16), .STAGES(2), .SAT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .op(op), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .ovf(ovf1), .ovf_sticky(st1),
    .ovf_clr(ovf_clr), .res_cnt(cnt1));
  pipe_addsub #(.W(16), .STAGES(3), .SAT(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .y(y2), .ovf(ovf2), .ovf_sticky(st2),
    .ovf_clr(ovf_clr), .res_cnt(cnt2));

  typedef struct {
    logic op;
    logic [15:0] a, b, yw, ys;
    logic ov;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic o, input logic [15:0] x, input logic [15:0] z, input bit sat);
    int sx, sz, r;
    logic ov;
    logic [15:0] res;
    sx = $signed(x);
    sz = $signed(z);
    r = o ? sx - sz : sx + sz;
    ov = (r > 32767) || (r < -32768);
    res = r[15:0];
    if (sat && ov) res = (r > 0) ? 16'h7fff : 16'h8000;
    return {ov, res};
  endfunction

  initial begin
    vec_t vt [8];
    logic [16:0] q [$];
    logic [16:0] e;
    logic exp_st, hold, ho, seen;
    logic [15:0] hy;
    int acc, nxt, ex, xf;
    vt[0] = '{1'b0, 16'h7fff, 16'h0001, 16'h8000, 16'h7fff, 1'b1};
    vt[1] = '{1'b1, 16'h8000, 16'h0001, 16'h7fff, 16'h8000, 1'b1};
    vt[2] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1};
    vt[3] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 16'h2345, 1'b0};
    vt[4] = '{1'b1, 16'h0000, 16'h0001, 16'hffff, 16'hffff, 1'b0};
    vt[5] = '{1'b1, 16'h7fff, 16'hffff, 16'h8000, 16'h7fff, 1'b1};
    vt[6] = '{1'b1, 16'h8000, 16'h7fff, 16'h0001, 16'h8000, 1'b1};
    vt[7] = '{1'b0, 16'hffff, 16'hffff, 16'hfffe, 16'hfffe, 1'b0};
    rst_n = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; op = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      in_valid2 = 1'b1; op2 = 1'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
      tick();
    end
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_y", y0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_sticky", st0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_out_valid2", out_valid2, 0);
    chk("rst_cnt2", cnt2, 0);
    rst_n = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    tick();
    chk("rel_in_ready", in_ready0, 1);
    chk("rel_out_valid", out_valid0, 0);
    chk("rel_in_ready2", in_ready2, 1);

    in_valid = 1'b1; a = 16'h0003; b = 16'h0004; op = 1'b0;
    tick();
    chk("lat_early_valid", out_valid0, 0);
    a = 16'h0003; b = 16'h0005; op = 1'b1;
    tick();
    chk("lat1_valid", out_valid0, 1);
    chk("lat1_y", y0, 16'h0007);
    chk("lat1_ovf", ovf0, 0);
    in_valid = 1'b0;
    tick();
    chk("lat2_valid", out_valid0, 1);
    chk("lat2_y", y0, 16'hfffe);
    tick();
    chk("lat_cnt", cnt0, 2);
    chk("lat_idle", out_valid0, 0);

    exp_st = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = vt[i].op; a = vt[i].a; b = vt[i].b;
      tick();
      in_valid = 1'b0;
      tick();
      chk($sformatf("v%0d_valid", i), out_valid0, 1);
      chk($sformatf("v%0d_wrap_y", i), y0, vt[i].yw);
      chk($sformatf("v%0d_wrap_ovf", i), ovf0, vt[i].ov);
      chk($sformatf("v%0d_sat_y", i), y1, vt[i].ys);
      chk($sformatf("v%0d_sat_ovf", i), ovf1, vt[i].ov);
      tick();
      exp_st = exp_st | vt[i].ov;
      chk($sformatf("v%0d_sticky", i), st0, exp_st);
    end

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_alone", st0, 0);
    in_valid = 1'b1; op = 1'b0; a = 16'h7fff; b = 16'h0001;
    tick();
    in_valid = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_vs_set", st0, 1);
    chk("cnt_before_rst", cnt0, 11);

    out_ready2 = 1'b0; nxt = 1; acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid2 = 1'b1; a2 = 16'(nxt); b2 = 16'h0; op2 = 1'b0;
      #1;
      if (in_ready2) begin acc++; nxt++; end
      tick();
    end
    a2 = 16'(nxt);
    #1;
    chk("bp_accepted", acc, 3);
    chk("bp_full_in_ready", in_ready2, 0);
    out_ready2 = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready2, 1);
    ex = 1;
    for (int c = 0; c < 8; c++) begin
      in_valid2 = (nxt <= 5); a2 = 16'(nxt);
      #1;
      if (c < 5) chk("bp_out_valid", out_valid2, 1);
      if (out_valid2) begin chk("bp_y", y2, ex); ex++; end
      if (in_valid2 && in_ready2) nxt++;
      tick();
    end
    chk("bp_count", ex, 6);
    chk("bp_all_in", nxt, 6);

    hold = 1'b0; hy = '0; ho = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      in_valid2 = 1'($urandom); op2 = 1'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
      out_ready2 = 1'($urandom);
      #1;
      if (hold) begin
        chk("hold_valid", out_valid2, 1);
        chk("hold_y", y2, hy);
        chk("hold_ovf", ovf2, ho);
      end
      chk("rnd_in_ready", in_ready2, (q.size() < 3) || out_ready2);
      if (out_valid2 && out_ready2) begin
        chk("rnd_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_result", {ovf2, y2}, e);
        end
      end
      if (in_valid2 && in_ready2) q.push_back(model(op2, a2, b2, 1'b1));
      hold = out_valid2 && !out_ready2; hy = y2; ho = ovf2;
      tick();
    end
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      #1;
      if (out_valid2) begin
        e = q.pop_front();
        chk("drain_result", {ovf2, y2}, e);
      end
      tick();
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", out_valid2, 0);

    in_valid = 1'b1; out_ready = 1'b0; a = 16'h0005; b = 16'h0005; op = 1'b0;
    tick();
    tick();
    chk("inflight_valid", out_valid0, 1);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("midrst_cnt", cnt0, 0);
    chk("midrst_sticky", st0, 0);
    for (int c = 0; c < 4; c++) begin
      chk("midrst_no_out", out_valid0, 0);
      tick();
    end
    chk("midrst_cnt_after", cnt0, 0);

    xf = 0; seen = 1'b0;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002; op = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 66000 && xf < 65536; c++) begin
      if (out_valid0) xf++;
      tick();
      if (xf == 65535 && !seen) begin
        seen = 1'b1;
        chk("cnt_ffff", cnt0, 16'hffff);
      end
    end
    in_valid = 1'b0;
    chk("wrap_xfers", xf, 65536);
    chk("cnt_wrap", cnt0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
